// File: rtl/pe_result_serializer_pkg.sv
// rtl/pe_result_serializer_pkg.sv - shared types and sizing helpers for the PE result serializer
// Optional checksum byte enabled by PE_SER_CHECKSUM_EN.
package pe_pkg;

  localparam int BYTE_W = 8;

`ifdef PE_SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif

  function automatic int bpw(input int output_width);
    return output_width / BYTE_W;
  endfunction

  function automatic int total_bytes(input int m, input int n, input int output_width);
    return m * n * bpw(output_width);
  endfunction

endpackage

// File: rtl/pe_result_serializer_if.sv
// rtl/pe_result_serializer_if.sv - byte stream bundle between the serializer and the output pins
interface pe_result_serializer_if;
  import pe_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_first;
  logic              byte_last;

  modport master (output byte_data, byte_valid, byte_first, byte_last, input byte_ready);
  modport slave  (input byte_data, byte_valid, byte_first, byte_last, output byte_ready);
endinterface

// File: rtl/pe_result_serializer_byte_select.sv
// rtl/pe_result_serializer_byte_select.sv - picks one byte of the snapshot by (word idx, byte idx)
module pe_byte_select
  import pe_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int OUTPUT_WIDTH = 32,
  parameter int WIDX_W       = 2,
  parameter int BIDX_W       = 2
) (
  input  logic [M*N*OUTPUT_WIDTH-1:0] snap,
  input  logic [WIDX_W-1:0]           word_idx,
  input  logic [BIDX_W-1:0]           byte_idx,
  output logic [BYTE_W-1:0]           byte_data
);
  localparam int WORDS = M * N;
  localparam int BPW   = bpw(OUTPUT_WIDTH);

  always_comb begin
    byte_data = '0;
    for (int k = 0; k < WORDS; k++) begin
      for (int b = 0; b < BPW; b++) begin
        if (word_idx == WIDX_W'(k) && byte_idx == BIDX_W'(b)) begin
          byte_data = snap[k*OUTPUT_WIDTH + b*BYTE_W +: BYTE_W];
        end
      end
    end
  end
endmodule

// File: rtl/pe_result_serializer.sv
// rtl/pe_result_serializer.sv - snapshots the PE accumulators and streams them out a byte at a time
// PE_SER_CHECKSUM_EN appends one XOR checksum byte to each frame.
module pe_result_serializer
  import pe_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [M*N*OUTPUT_WIDTH-1:0] data_in,
  input  logic                        capture,
  pe_result_serializer_if.master      bs,
  output logic                        busy,
  output logic                        done
);
  localparam int WORDS  = M * N;
  localparam int BPW    = bpw(OUTPUT_WIDTH);
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  generate
    if (OUTPUT_WIDTH % BYTE_W != 0) begin : g_width_check
      $error("OUTPUT_WIDTH must be a multiple of 8");
    end
  endgenerate

  state_e                      state_q, state_d;
  logic [M*N*OUTPUT_WIDTH-1:0] snap_q, snap_d;
  logic [WIDX_W-1:0]           word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]           byte_idx_q, byte_idx_d;
  logic                        done_q, done_d;
  logic [BYTE_W-1:0]           sel_byte;
  logic                        xfer, last_data, last_in_word;
`ifdef PE_SER_CHECKSUM_EN
  logic [BYTE_W-1:0]           xor_q, xor_d;
`endif

  pe_byte_select #(
    .M(M), .N(N), .OUTPUT_WIDTH(OUTPUT_WIDTH), .WIDX_W(WIDX_W), .BIDX_W(BIDX_W)
  ) u_byte_select (
    .snap(snap_q), .word_idx(word_idx_q), .byte_idx(byte_idx_q), .byte_data(sel_byte)
  );

  assign xfer         = bs.byte_valid & bs.byte_ready;
  assign last_in_word = (byte_idx_q == BIDX_W'(BPW - 1));
  assign last_data    = last_in_word && (word_idx_q == WIDX_W'(WORDS - 1));

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
`ifdef PE_SER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d    = SEND;
          snap_d     = data_in;
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef PE_SER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef PE_SER_CHECKSUM_EN
          xor_d = xor_q ^ sel_byte;
`endif
          if (last_data) begin
            word_idx_d = '0;
            byte_idx_d = '0;
`ifdef PE_SER_CHECKSUM_EN
            state_d    = CSUM;
`else
            state_d    = IDLE;
            done_d     = 1'b1;
`endif
          end else if (last_in_word) begin
            byte_idx_d = '0;
            word_idx_d = word_idx_q + WIDX_W'(1);
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end
      end
`ifdef PE_SER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // byte_data is forced to zero outside a frame so idle pins never show stale snapshot data
  always_comb begin
    bs.byte_valid = (state_q != IDLE);
    bs.byte_first = (state_q == SEND) && (word_idx_q == '0) && (byte_idx_q == '0);
`ifdef PE_SER_CHECKSUM_EN
    bs.byte_last  = (state_q == CSUM);
    bs.byte_data  = (state_q == CSUM) ? xor_q : ((state_q == SEND) ? sel_byte : '0);
`else
    bs.byte_last  = (state_q == SEND) && last_data;
    bs.byte_data  = (state_q == SEND) ? sel_byte : '0;
`endif
    busy = (state_q != IDLE);
    done = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
`ifdef PE_SER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      done_q     <= done_d;
`ifdef PE_SER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end
endmodule

// File: tb/tb_pe_result_serializer.sv
// tb/tb_pe_result_serializer.sv - scoreboard bench for pe_result_serializer (honours PE_SER_CHECKSUM_EN)
module tb_pe_result_serializer;
  import pe_pkg::*;

  localparam int M = 2, N = 2, OW = 32;
  localparam int TOTAL = 16;
`ifdef PE_SER_CHECKSUM_EN
  localparam bit CS = 1'b1;
  localparam int FRAME = TOTAL + 1;
`else
  localparam bit CS = 1'b0;
  localparam int FRAME = TOTAL;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              capture;
  logic [M*N*OW-1:0] data_in;
  logic              busy, done;

  pe_result_serializer_if bs ();

  pe_result_serializer #(.M(M), .N(N), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .capture(capture),
    .bs(bs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic f; logic l; logic [7:0] d; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [M*N*OW-1:0] d);
    logic [7:0] x, b;
    int i;
    x = '0;
    i = 0;
    for (int k = 0; k < M*N; k++) begin
      for (int bb = 0; bb < OW/8; bb++) begin
        b = d[k*OW + bb*8 +: 8];
        x ^= b;
        exp_q.push_back(exp_t'{f: (i == 0), l: (i == TOTAL-1) && !CS, d: b});
        i++;
      end
    end
    if (CS) exp_q.push_back(exp_t'{f: 1'b0, l: 1'b1, d: x});
  endfunction

  // Every valid cycle is compared against the queue head; pop only on transfer, so stalls must hold.
  always @(negedge clk) begin
    if (!rst && bs.byte_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(bs.byte_valid), 32'd0);
      end else begin
        check("byte", 32'({bs.byte_first, bs.byte_last, bs.byte_data}), 32'(exp_q[0]));
        if (bs.byte_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic start_frame(input logic [M*N*OW-1:0] d);
    data_in = d;
    capture = 1'b1;
    push_frame(d);
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0 repeating
  task automatic stream(input int mode, input bit busy_cap, output int done_cyc);
    int  base;
    bit  capped;
    capped   = 1'b0;
    done_cyc = -1;
    @(posedge clk);
    #1 capture = 1'b0;
    base = xfers;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bs.byte_ready = (mode == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
      if (busy_cap && !capped && (xfers - base) == 5) begin
        capture = 1'b1;
        data_in = '1;
        capped  = 1'b1;
      end else begin
        capture = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [M*N*OW-1:0] d2, d3, d5;
  int dc;

  initial begin
    d2 = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
    d3 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hA5C3_5A3C};
    d5 = {32'h77665544, 32'h33221100, 32'hFFEEDDCC, 32'hBBAA9988};
    rst = 1'b1; capture = 1'b0; data_in = '0; bs.byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bs.byte_valid), 0);
    check("rst_data",  32'(bs.byte_data), 0);
    check("rst_flags", 32'({bs.byte_first, bs.byte_last}), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);

    // Reset in the middle of a frame
    start_frame(d3);
    @(posedge clk);
    #1 capture = 1'b0; bs.byte_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(bs.byte_valid), 0);
    check("midrst_busy",  32'(busy), 0);
    check("midrst_done",  32'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_done", 32'(done), 0);
    check("postrst_busy", 32'(busy), 0);

    // Basic frame, ready held high
    start_frame(d2);
    stream(0, 1'b0, dc);
    check("basic_done_cycle", 32'(dc), 32'(FRAME + 1));
    check("basic_busy_at_done", 32'(busy), 0);
    check("basic_queue_empty", 32'(exp_q.size()), 0);

    // Backpressure
    start_frame(d3);
    stream(1, 1'b0, dc);
    check("bp_done_seen", 32'(dc > 0), 1);
    check("bp_queue_empty", 32'(exp_q.size()), 0);

    // Capture while busy with data_in changed to all ones
    start_frame(d2);
    stream(0, 1'b1, dc);
    check("busycap_done_cycle", 32'(dc), 32'(FRAME + 1));
    check("busycap_queue_empty", 32'(exp_q.size()), 0);

    // Capture in the done cycle starts the next frame immediately
    check("donecap_busy", 32'(busy), 0);
    start_frame(d5);
    stream(0, 1'b0, dc);
    check("donecap_done_cycle", 32'(dc), 32'(FRAME + 1));
    check("donecap_queue_empty", 32'(exp_q.size()), 0);

    @(negedge clk);
    check("final_done_low", 32'(done), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
